dual_ram_arbiter: RTL

//  Shares one dual_ram (1 write port + 1 read port, 1-cycle read latency) between two requesters:
//  M0 (debug/loader) and M1 (core LSU). Write and read ports are arbitrated independently.
//  A write from one master and a read from the other can be granted in the same cycle.

---
 rtl/dual_ram_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dual_ram_arbiter.sv
// Two-master arbiter in front of a 1W/1R dual_ram (1-cycle read latency).
// Write and read ports arbitrate independently with toggling priority.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   mN_req/we/addr/wdata request from master N (0=debug/loader, 1=LSU)
//   mN_gnt               combinational accept
//   mN_rvalid/rdata      read return, one cycle after a granted read
//   mN_err               out-of-range flag (with gnt for writes, rvalid for reads)
//   ram_*                dual_ram write/read port
module dual_ram_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int MEM_NUM = 4096
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          ram_wen,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
  output logic          ram_ren,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_data
);

  // One extra bit so a depth of 2**AW still compares correctly.
  localparam logic [AW:0] LIMIT = (AW+1)'(MEM_NUM);

  // Priority flops: 0 = M0 wins the next conflict, 1 = M1 wins.
  logic wr_prio_q, wr_prio_d;
  logic rd_prio_q, rd_prio_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;
  logic rd_err_q, rd_err_d;

  logic          wr_c0, wr_c1;
  logic          rd_c0, rd_c1;
  logic          wr_sel1, rd_sel1;
  logic          wr_any, rd_any;
  logic          wr_oor, rd_oor;
  logic          wr_gnt0, wr_gnt1;
  logic          rd_gnt0, rd_gnt1;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          rv0, rv1;

  always_comb begin
    wr_c0 = m0_req & m0_we;
    wr_c1 = m1_req & m1_we;
    rd_c0 = m0_req & ~m0_we;
    rd_c1 = m1_req & ~m1_we;

    // M1 wins when alone or when it holds priority.
    wr_sel1 = wr_c1 & (~wr_c0 | wr_prio_q);
    rd_sel1 = rd_c1 & (~rd_c0 | rd_prio_q);
    wr_any  = wr_c0 | wr_c1;
    rd_any  = rd_c0 | rd_c1;

    wr_gnt0 = rstn & wr_c0 & ~wr_sel1;
    wr_gnt1 = rstn & wr_sel1;
    rd_gnt0 = rstn & rd_c0 & ~rd_sel1;
    rd_gnt1 = rstn & rd_sel1;

    // Idle muxes fall back to M0 so the RAM never sees X.
    wr_addr = wr_sel1 ? m1_addr : m0_addr;
    wr_data = wr_sel1 ? m1_wdata : m0_wdata;
    rd_addr = rd_sel1 ? m1_addr : m0_addr;

    wr_oor = {1'b0, wr_addr} >= LIMIT;
    rd_oor = {1'b0, rd_addr} >= LIMIT;
  end

  always_comb begin
    wr_prio_d  = wr_prio_q;
    rd_prio_d  = rd_prio_q;
    rd_pend_d  = rd_any;
    rd_owner_d = rd_owner_q;
    rd_err_d   = rd_err_q;
    // Priority moves only when both masters contend.
    if (wr_c0 & wr_c1) wr_prio_d = ~wr_prio_q;
    if (rd_c0 & rd_c1) rd_prio_d = ~rd_prio_q;
    if (rd_any) begin
      rd_owner_d = rd_sel1;
      rd_err_d   = rd_oor;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_prio_q  <= 1'b0;
      rd_prio_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_prio_q  <= wr_prio_d;
      rd_prio_q  <= rd_prio_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign ram_wen    = rstn & wr_any & ~wr_oor;
  assign ram_w_addr = wr_addr;
  assign ram_w_data = wr_data;
  assign ram_ren    = rstn & rd_any & ~rd_oor;
  assign ram_r_addr = rd_addr;

  assign rv0 = rstn & rd_pend_q & ~rd_owner_q;
  assign rv1 = rstn & rd_pend_q & rd_owner_q;

  assign m0_gnt    = wr_gnt0 | rd_gnt0;
  assign m1_gnt    = wr_gnt1 | rd_gnt1;
  assign m0_rvalid = rv0;
  assign m1_rvalid = rv1;
  // Out-of-range reads never touched the RAM, so return zero.
  assign m0_rdata  = rd_err_q ? '0 : ram_r_data;
  assign m1_rdata  = rd_err_q ? '0 : ram_r_data;
  assign m0_err    = (wr_gnt0 & wr_oor) | (rv0 & rd_err_q);
  assign m1_err    = (wr_gnt1 & wr_oor) | (rv1 & rd_err_q);

endmodule
